nios2os_sysinfo_qsys: RTL and testbench



---
 rtl/nios2os_sysinfo_pkg.sv | 34 +++
 rtl/nios2os_sysinfo_uptime.sv | 38 +++
 rtl/nios2os_sysinfo_qsys.sv | 157 +++++++++++++++
 tb/tb_nios2os_sysinfo_qsys.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2os_sysinfo_pkg.sv
// Shared register map, field positions and word builders for the Nios II
// system-information slave.
package nios2os_sysinfo_pkg;

    // Word addresses within the 32-word slave window
    localparam logic [4:0] ADDR_ID          = 5'd0;
    localparam logic [4:0] ADDR_TIMESTAMP   = 5'd1;
    localparam logic [4:0] ADDR_VERSION     = 5'd2;
    localparam logic [4:0] ADDR_CAPS        = 5'd3;
    localparam logic [4:0] ADDR_UPTIME_LO   = 5'd4;
    localparam logic [4:0] ADDR_UPTIME_HI   = 5'd5;
    localparam logic [4:0] ADDR_SCRATCH     = 5'd6;
    localparam logic [4:0] ADDR_TICK_CTRL   = 5'd7;
    localparam logic [4:0] ADDR_TICK_PERIOD = 5'd8;
    localparam logic [4:0] ADDR_USER_BASE   = 5'd16;

    localparam int MAX_USER = 16;

    localparam int VERSION_HW_LSB       = 0;
    localparam int VERSION_NUM_USER_LSB = 16;
    localparam int CAPS_TICK_BIT        = 0;
    localparam int CAPS_UPTIME_W_LSB    = 8;
    localparam int TICK_EN_BIT          = 0;
    localparam int TICK_PEND_BIT        = 1;

    function automatic logic [31:0] version_word(input int num_user, input logic [15:0] hw_version);
        return (32'(num_user[15:0]) << VERSION_NUM_USER_LSB) | (32'(hw_version) << VERSION_HW_LSB);
    endfunction

    function automatic logic [31:0] caps_word(input logic tick_impl, input int uptime_w);
        return (32'(tick_impl) << CAPS_TICK_BIT) | (32'(uptime_w[7:0]) << CAPS_UPTIME_W_LSB);
    endfunction

endpackage

// File: rtl/nios2os_sysinfo_uptime.sv
// Free-running uptime counter. A LO read (snap) latches the upper bits into a
// shadow so that a later HI read pairs coherently with the LO value.
module nios2os_sysinfo_uptime #(
    parameter int UPTIME_W = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [UPTIME_W-1:0]    count_reg;
    logic [UPTIME_W-33:0]   shadow_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            shadow_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
            if (snap) begin
                shadow_reg <= count_reg[UPTIME_W-1:32];
            end
        end
    end

    assign lo = count_reg[31:0];

    generate
        if (UPTIME_W == 64) begin : g_hi_full
            assign hi = shadow_reg;
        end else begin : g_hi_ext
            assign hi = {{(64-UPTIME_W){1'b0}}, shadow_reg};
        end
    endgenerate

endmodule

// File: rtl/nios2os_sysinfo_qsys.sv
// System-information Avalon-MM slave: ID/timestamp/version/caps, user words,
// coherent uptime, scratch and an optional tick IRQ (macro SYSINFO_TICK_IRQ_EN).
module nios2os_sysinfo_qsys
    import nios2os_sysinfo_pkg::*;
#(
    parameter logic [31:0]  SYSTEM_ID  = 32'h0000_0002,
    parameter logic [31:0]  TIMESTAMP  = 32'd1548746340,
    parameter logic [15:0]  HW_VERSION = 16'h0001,
    parameter int           NUM_USER   = 4,
    parameter logic [511:0] USER_INIT  = 512'h0,
    parameter int           ADDR_W     = 5,
    parameter int           UPTIME_W   = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic              irq
);

`ifdef SYSINFO_TICK_IRQ_EN
    localparam logic TICK_IMPL = 1'b1;
`else
    localparam logic TICK_IMPL = 1'b0;
`endif

    localparam logic [31:0] VERSION_WORD = version_word(NUM_USER, HW_VERSION);
    localparam logic [31:0] CAPS_WORD    = caps_word(TICK_IMPL, UPTIME_W);

    logic [31:0] rdata_reg;
    logic        rvalid_reg;
    logic [31:0] scratch_reg;
    logic [31:0] read_word;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi;
    logic [31:0] user_words [MAX_USER];
    logic        snap;
    logic        wr_scratch;

    assign snap       = read  && (address == ADDR_UPTIME_LO);
    assign wr_scratch = write && (address == ADDR_SCRATCH);

    nios2os_sysinfo_uptime #(
        .UPTIME_W (UPTIME_W)
    ) u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .snap    (snap),
        .lo      (uptime_lo),
        .hi      (uptime_hi)
    );

    // Unpopulated user slots are hard zero so they read like unmapped space
    generate
        for (genvar gi = 0; gi < MAX_USER; gi++) begin : g_user
            if (gi < NUM_USER) begin : g_on
                assign user_words[gi] = USER_INIT[32*gi +: 32];
            end else begin : g_off
                assign user_words[gi] = 32'h0;
            end
        end
    endgenerate

`ifdef SYSINFO_TICK_IRQ_EN
    logic        tick_en_reg;
    logic        tick_pend_reg;
    logic [31:0] tick_period_reg;
    logic [31:0] tick_cnt_reg;
    logic        wr_ctrl;
    logic        wr_period;
    logic        tick_run;
    logic        tick_hit;

    assign wr_ctrl   = write && (address == ADDR_TICK_CTRL);
    assign wr_period = write && (address == ADDR_TICK_PERIOD);
    assign tick_run  = tick_en_reg && (tick_period_reg != 32'h0);
    // A period rewrite restarts the count, so it also suppresses this cycle's tick
    assign tick_hit  = tick_run && !wr_period && (tick_cnt_reg == tick_period_reg - 32'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_en_reg     <= 1'b0;
            tick_pend_reg   <= 1'b0;
            tick_period_reg <= 32'h0;
            tick_cnt_reg    <= 32'h0;
        end else begin
            if (wr_ctrl) begin
                tick_en_reg <= writedata[TICK_EN_BIT];
            end
            if (wr_period) begin
                tick_period_reg <= writedata;
                tick_cnt_reg    <= 32'h0;
            end else if (tick_hit) begin
                tick_cnt_reg    <= 32'h0;
            end else if (tick_run) begin
                tick_cnt_reg    <= tick_cnt_reg + 32'd1;
            end
            if (tick_hit) begin
                tick_pend_reg <= 1'b1;
            end else if (wr_ctrl && writedata[TICK_PEND_BIT]) begin
                tick_pend_reg <= 1'b0;
            end
        end
    end

    assign irq = tick_pend_reg & tick_en_reg;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        read_word = 32'h0;
        case (address)
            ADDR_ID:          read_word = SYSTEM_ID;
            ADDR_TIMESTAMP:   read_word = TIMESTAMP;
            ADDR_VERSION:     read_word = VERSION_WORD;
            ADDR_CAPS:        read_word = CAPS_WORD;
            ADDR_UPTIME_LO:   read_word = uptime_lo;
            ADDR_UPTIME_HI:   read_word = uptime_hi;
            ADDR_SCRATCH:     read_word = scratch_reg;
`ifdef SYSINFO_TICK_IRQ_EN
            ADDR_TICK_CTRL:   read_word = (32'(tick_pend_reg) << TICK_PEND_BIT)
                                        | (32'(tick_en_reg) << TICK_EN_BIT);
            ADDR_TICK_PERIOD: read_word = tick_period_reg;
`endif
            default: begin
                if (address[4] && (int'(address[3:0]) < NUM_USER)) begin
                    read_word = user_words[address[3:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_reg   <= 32'h0;
            rvalid_reg  <= 1'b0;
            scratch_reg <= 32'h0;
        end else begin
            rvalid_reg <= read;
            if (read) begin
                rdata_reg <= read_word;
            end
            if (wr_scratch) begin
                scratch_reg <= writedata;
            end
        end
    end

    assign readdata      = rdata_reg;
    assign readdatavalid = rvalid_reg;

endmodule

// File: tb/tb_nios2os_sysinfo_qsys.sv
// Directed self-checking bench for nios2os_sysinfo_qsys; tick expectations
// follow whether SYSINFO_TICK_IRQ_EN is defined for the build.
module tb_nios2os_sysinfo_qsys;

    localparam logic [511:0] USER_INIT_TB = {352'h0, 32'h5555_5555, 32'h4444_4444,
                                             32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
`ifdef SYSINFO_TICK_IRQ_EN
    localparam logic [31:0] CAPS_EXP = 32'h0000_4001;
`else
    localparam logic [31:0] CAPS_EXP = 32'h0000_4000;
`endif

    logic        clock;
    logic        reset_n;
    logic [4:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    int n_cmp;
    int n_bad;

    nios2os_sysinfo_qsys #(
        .NUM_USER  (4),
        .USER_INIT (USER_INIT_TB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .irq           (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at a negedge; issues a one-cycle read and returns at the next negedge
    task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic v);
        read    = 1'b1;
        address = a;
        @(negedge clock);
        read = 1'b0;
        d = readdata;
        v = readdatavalid;
        $display("read  addr=%0d data=%h valid=%b", a, d, v);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] data);
        write     = 1'b1;
        address   = a;
        writedata = data;
        @(negedge clock);
        write = 1'b0;
        $display("write addr=%0d data=%h", a, data);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_words [4];
        exp_words[0] = 32'h0000_0002;
        exp_words[1] = 32'd1548746340;
        exp_words[2] = 32'h0004_0001;
        exp_words[3] = CAPS_EXP;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_rdv: got %b expected 0", readdatavalid); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            do_read(5'(i), d, v);
            n_cmp++; if (d !== exp_words[i]) begin n_bad++; $display("FAIL id_word%0d: got %h expected %h", i, d, exp_words[i]); end
            n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL id_rdv%0d: got %b expected 1", i, v); end
        end
        @(negedge clock);
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL rdv_pulse: got %b expected 0", readdatavalid); end
        n_cmp++; if (readdata !== CAPS_EXP) begin n_bad++; $display("FAIL readdata_hold: got %h expected %h", readdata, CAPS_EXP); end
    endtask

    task automatic test_uptime_coherent();
        logic [31:0] d;
        logic        v;
        force dut.u_uptime.count_reg = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_uptime.count_reg;
        do_read(5'd4, d, v);
        n_cmp++; if (d !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL uptime_lo: got %h expected %h", d, 32'hFFFF_FFFE); end
        repeat (4) @(negedge clock);
        do_read(5'd5, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL uptime_hi_shadow: got %h expected %h", d, 32'h0); end
        do_read(5'd4, d, v);
        n_cmp++; if (d !== 32'h0000_0004) begin n_bad++; $display("FAIL uptime_lo2: got %h expected %h", d, 32'h4); end
        do_read(5'd5, d, v);
        n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL uptime_hi2: got %h expected %h", d, 32'h1); end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic        v;
        read      = 1'b1;
        write     = 1'b1;
        address   = 5'd6;
        writedata = 32'hA5A5_5A5A;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        $display("rdwr  addr=6 wdata=a5a55a5a rdata=%h valid=%b", readdata, readdatavalid);
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL scratch_same_cycle: got %h expected %h", readdata, 32'h0); end
        do_read(5'd6, d, v);
        n_cmp++; if (d !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL scratch_readback: got %h expected %h", d, 32'hA5A5_5A5A); end
        write_reg(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, d, v);
        n_cmp++; if (d !== 32'h0000_0002) begin n_bad++; $display("FAIL ro_write_ignored: got %h expected %h", d, 32'h2); end
    endtask

    task automatic test_user_unmapped();
        logic [31:0] d;
        logic        v;
        do_read(5'd18, d, v);
        n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL user2: got %h expected %h", d, 32'hDEAD_BEEF); end
        do_read(5'd9, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped9: got %h expected %h", d, 32'h0); end
        do_read(5'd16, d, v);
        n_cmp++; if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL user0: got %h expected %h", d, 32'h1111_1111); end
        do_read(5'd20, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped20: got %h expected %h", d, 32'h0); end
        do_read(5'd19, d, v);
        n_cmp++; if (d !== 32'h4444_4444) begin n_bad++; $display("FAIL user3: got %h expected %h", d, 32'h4444_4444); end
    endtask

`ifdef SYSINFO_TICK_IRQ_EN
    task automatic test_tick();
        logic [31:0] d;
        logic        v;
        write_reg(5'd8, 32'd10);
        write_reg(5'd7, 32'h1);
        repeat (9) @(negedge clock);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tick_early: got %b expected 0", irq); end
        @(negedge clock);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tick_rise: got %b expected 1", irq); end
        write_reg(5'd7, 32'h3);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tick_w1c: got %b expected 0", irq); end
        repeat (8) @(negedge clock);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tick_before2: got %b expected 0", irq); end
        write_reg(5'd7, 32'h3);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tick_set_wins: got %b expected 1", irq); end
        do_read(5'd7, d, v);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL tick_ctrl_rd: got %h expected %h", d, 32'h3); end
        do_read(5'd8, d, v);
        n_cmp++; if (d !== 32'd10) begin n_bad++; $display("FAIL tick_period_rd: got %h expected %h", d, 32'd10); end
        write_reg(5'd7, 32'h0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tick_disable_irq: got %b expected 0", irq); end
        do_read(5'd7, d, v);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL tick_pend_kept: got %h expected %h", d, 32'h2); end
    endtask
`else
    task automatic test_tick();
        logic [31:0] d;
        logic        v;
        write_reg(5'd8, 32'd10);
        write_reg(5'd7, 32'h1);
        repeat (15) @(negedge clock);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL notick_irq: got %b expected 0", irq); end
        do_read(5'd0, d, v);
        do_read(5'd7, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL notick_ctrl: got %h expected %h", d, 32'h0); end
        do_read(5'd0, d, v);
        do_read(5'd8, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL notick_period: got %h expected %h", d, 32'h0); end
    endtask
`endif

    task automatic test_reset_midread();
        logic [31:0] d;
        logic        v;
        write_reg(5'd6, 32'h1234_5678);
        read    = 1'b1;
        address = 5'd0;
        @(posedge clock);
        #1;
        read = 1'b0;
        n_cmp++; if (readdatavalid !== 1'b1) begin n_bad++; $display("FAIL midread_pending: got %b expected 1", readdatavalid); end
        #1;
        reset_n = 1'b0;
        #1;
        $display("reset asserted mid-read rdata=%h valid=%b", readdata, readdatavalid);
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL midread_rdv_drop: got %b expected 0", readdatavalid); end
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL midread_rdata: got %h expected %h", readdata, 32'h0); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        do_read(5'd4, d, v);
        n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL uptime_restart: got %h expected %h", d, 32'd3); end
        do_read(5'd6, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL scratch_reset: got %h expected %h", d, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_after_reset: got %b expected 0", irq); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 5'd0;
        writedata = 32'h0;
        @(negedge clock);
        test_reset();
        test_uptime_coherent();
        test_scratch();
        test_user_unmapped();
        test_tick();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
